// File: rtl/lsu_dmem_pkg.sv
// Shared encodings for the handshaked data memory: access sizes, fault causes and FSM states.
package lsu_dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_RANGE    = 2'd2,
        CAUSE_SIZE     = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Low address bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            SZ_B:    align_mask = 3'b000;
            SZ_H:    align_mask = 3'b001;
            SZ_W:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem_align.sv
// Byte-lane steering: store byte enables / shifted data, load extract with sign or zero extension.
module lsu_dmem_align
    import lsu_dmem_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [1:0]       st_size,
    input  logic [OFF_W-1:0] st_off,
    input  logic [XLEN-1:0]  st_wdata,
    output logic [NB-1:0]    byte_en,
    output logic [XLEN-1:0]  wr_data,
    input  logic [1:0]       ld_size,
    input  logic [OFF_W-1:0] ld_off,
    input  logic             ld_signed,
    input  logic [XLEN-1:0]  ld_word,
    output logic [XLEN-1:0]  ld_data
);

    logic [NB-1:0]   base_en;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic            sign_bit;

    always_comb begin
        case (st_size)
            SZ_B:    base_en = NB'(8'h01);
            SZ_H:    base_en = NB'(8'h03);
            SZ_W:    base_en = NB'(8'h0F);
            default: base_en = '1;
        endcase
        byte_en = base_en << st_off;
        wr_data = st_wdata << {st_off, 3'b000};
    end

    // Addressed lanes land at bit 0; upper bits are then masked off or filled with the sign.
    always_comb begin
        shifted = ld_word >> {ld_off, 3'b000};
        case (ld_size)
            SZ_B: begin
                keep     = XLEN'(8'hFF);
                sign_bit = shifted[7];
            end
            SZ_H: begin
                keep     = XLEN'(16'hFFFF);
                sign_bit = shifted[15];
            end
            SZ_W: begin
                keep     = XLEN'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            default: begin
                keep     = '1;
                sign_bit = 1'b0;
            end
        endcase
        ld_data = (shifted & keep) | ((ld_signed && sign_bit) ? ~keep : '0);
    end

endmodule

// File: rtl/lsu_dmem.sv
// Handshaked data memory: request fault check, byte-lane RAM, latency counter and response FSM.
module lsu_dmem
    import lsu_dmem_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic            req_signed,
    input  logic [1:0]      req_size,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [1:0]      resp_cause
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e             state;
    logic [1:0]         cnt;
    cause_e             cause;
    logic               fault;
    logic               accept;
    logic [IDX_W-1:0]   req_idx;
    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   cap_idx;
    logic [OFF_W-1:0]   cap_off;
    logic [1:0]         cap_size;
    logic               cap_signed;
    logic [IDX_W-1:0]   ld_idx;
    logic [OFF_W-1:0]   ld_off;
    logic [1:0]         ld_size;
    logic               ld_signed;
    logic [NB-1:0]      byte_en;
    logic [XLEN-1:0]    wr_data;
    logic [XLEN-1:0]    ld_data;
    logic [XLEN-1:0]    mem [DEPTH_WORDS];

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_idx   = req_addr[OFF_W +: IDX_W];
    assign req_off   = req_addr[OFF_W-1:0];

    always_comb begin
        cause = CAUSE_NONE;
        if (int'(req_size) > OFF_W)
            cause = CAUSE_SIZE;
        else if ((req_addr[2:0] & align_mask(req_size)) != 3'b000)
            cause = CAUSE_MISALIGN;
        else if ((req_addr >> OFF_W) >= 32'(DEPTH_WORDS))
            cause = CAUSE_RANGE;
        fault = (cause != CAUSE_NONE);
    end

    // In IDLE the load path looks at the live request so a 1-cycle read can respond directly.
    assign ld_idx    = req_ready ? req_idx    : cap_idx;
    assign ld_off    = req_ready ? req_off    : cap_off;
    assign ld_size   = req_ready ? req_size   : cap_size;
    assign ld_signed = req_ready ? req_signed : cap_signed;

    lsu_dmem_align #(.XLEN(XLEN)) u_align (
        .st_size  (req_size),
        .st_off   (req_off),
        .st_wdata (req_wdata),
        .byte_en  (byte_en),
        .wr_data  (wr_data),
        .ld_size  (ld_size),
        .ld_off   (ld_off),
        .ld_signed(ld_signed),
        .ld_word  (mem[ld_idx]),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst_n && accept && req_we && !fault) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_en[i])
                    mem[req_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_idx    <= req_idx;
            cap_off    <= req_off;
            cap_size   <= req_size;
            cap_signed <= req_signed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_cause <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cnt        <= 2'(READ_LATENCY - 1);
                        resp_err   <= fault;
                        resp_cause <= cause;
                        if (fault || req_we || READ_LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= (fault || req_we) ? '0 : ld_data;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 2'd1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= ld_data;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// Bench for lsu_dmem (XLEN=32, 1024 words, 2-cycle reads): directed plan plus randomized traffic vs a byte-array model.
module tb_lsu_dmem;

    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;
    localparam int RL    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_cause;

    lsu_dmem #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_signed(req_signed), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .resp_cause(resp_cause)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Behavioural model: byte-addressed memory plus one outstanding transaction with a due countdown.
    logic [7:0]  mm [DEPTH*4];
    bit          kn [DEPTH*4];
    bit          m_busy = 0, m_valid = 0, m_err = 0, m_known = 0;
    int          m_cnt = 0;
    logic [1:0]  m_cause = 2'd0;
    logic [31:0] m_rdata = 32'd0;
    int          nb, a;
    longint      v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 0;
            m_valid = 0;
        end else if (m_valid) begin
            if (resp_ready) begin
                m_valid = 0;
                m_busy  = 0;
            end
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1;
        end else if (req_valid) begin
            nb = 1 << req_size;
            a  = int'(req_addr);
            m_busy  = 1;
            m_rdata = 32'd0;
            m_known = 1;
            if (req_size > 2)                  m_cause = 2'd3;
            else if (req_addr % nb != 0)       m_cause = 2'd1;
            else if (req_addr / 4 >= DEPTH)    m_cause = 2'd2;
            else                               m_cause = 2'd0;
            m_err = (m_cause != 2'd0);
            if (!m_err && req_we) begin
                for (int i = 0; i < nb; i++) begin
                    mm[a+i] = req_wdata[8*i +: 8];
                    kn[a+i] = 1;
                end
            end else if (!m_err) begin
                v = 0;
                for (int i = 0; i < nb; i++) begin
                    v += longint'(mm[a+i]) << (8*i);
                    if (!kn[a+i]) m_known = 0;
                end
                if (req_signed && v >= (longint'(1) << (8*nb-1))) v -= longint'(1) << (8*nb);
                m_rdata = v[31:0];
            end
            m_cnt = (m_err || req_we) ? 1 : RL;
            m_cnt--;
            if (m_cnt == 0) m_valid = 1;
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            check("cmp_resp_valid_in_reset", 64'(resp_valid), 64'd0);
        end else begin
            check("cmp_req_ready", 64'(req_ready), 64'(!m_busy));
            check("cmp_resp_valid", 64'(resp_valid), 64'(m_valid));
            if (m_valid) begin
                check("cmp_resp_err", 64'(resp_err), 64'(m_err));
                check("cmp_resp_cause", 64'(resp_cause), 64'(m_cause));
                if (m_known) check("cmp_resp_rdata", 64'(resp_rdata), 64'(m_rdata));
            end
        end
    end

    task automatic do_req(input bit we, input bit sg, input logic [1:0] sz, input logic [31:0] ad,
                          input logic [31:0] wd, input int hold, output logic [31:0] rd,
                          output logic e, output logic [1:0] c, output int edges);
        @(negedge clk);
        req_we = we; req_signed = sg; req_size = sz; req_addr = ad; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_wdata  = $urandom;
        edges = 1;
        while (!resp_valid && edges < 10) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        rd = resp_rdata; e = resp_err; c = resp_cause;
        if (!resp_valid) begin
            n_checks++;
            $display("FAIL resp_timeout: resp_valid low after %0d edges, required high", edges);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_resp_valid", 64'(resp_valid), 64'd1);
            check("hold_resp_rdata", 64'(resp_rdata), 64'(rd));
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("post_hs_resp_valid", 64'(resp_valid), 64'd0);
        check("post_hs_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        logic [1:0]  c;
        int          ed;

        repeat (3) @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_resp_rdata", 64'(resp_rdata), 64'd0);
        check("reset_resp_err", 64'(resp_err), 64'd0);
        check("reset_resp_cause", 64'(resp_cause), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_req(1, 0, 2'd2, 32'h100, 32'hDEADBEEF, 0, rd, e, c, ed);
        check("sw_err", 64'(e), 64'd0);
        check("sw_latency", 64'(ed), 64'd1);
        do_req(0, 1, 2'd0, 32'h103, 32'h0, 0, rd, e, c, ed);
        check("lb_signed", 64'(rd), 64'hFFFFFFDE);
        check("lb_latency", 64'(ed), 64'd2);
        do_req(0, 0, 2'd0, 32'h103, 32'h0, 0, rd, e, c, ed);
        check("lbu", 64'(rd), 64'h000000DE);
        check("lbu_latency", 64'(ed), 64'd2);
        do_req(0, 1, 2'd1, 32'h100, 32'h0, 0, rd, e, c, ed);
        check("lh_signed", 64'(rd), 64'hFFFFBEEF);
        check("lh_latency", 64'(ed), 64'd2);
        do_req(1, 0, 2'd0, 32'h101, 32'hABCDEF55, 0, rd, e, c, ed);
        do_req(0, 0, 2'd2, 32'h100, 32'h0, 0, rd, e, c, ed);
        check("lw_after_sb", 64'(rd), 64'hDEAD55EF);

        do_req(0, 1, 2'd1, 32'h101, 32'h0, 0, rd, e, c, ed);
        check("lh_misalign_err", 64'(e), 64'd1);
        check("lh_misalign_cause", 64'(c), 64'd1);
        check("lh_misalign_rdata", 64'(rd), 64'd0);
        check("lh_misalign_latency", 64'(ed), 64'd1);
        do_req(1, 0, 2'd2, 32'h102, 32'h12345678, 0, rd, e, c, ed);
        check("sw_misalign_cause", 64'(c), 64'd1);
        do_req(0, 0, 2'd2, 32'h100, 32'h0, 0, rd, e, c, ed);
        check("lw_after_faulted_sw", 64'(rd), 64'hDEAD55EF);
        do_req(0, 0, 2'd2, 32'h1000, 32'h0, 0, rd, e, c, ed);
        check("lw_range_cause", 64'(c), 64'd2);
        do_req(0, 0, 2'd3, 32'h0, 32'h0, 0, rd, e, c, ed);
        check("size3_cause", 64'(c), 64'd3);
        do_req(0, 0, 2'd3, 32'h1, 32'h0, 0, rd, e, c, ed);
        check("size3_misaligned_cause", 64'(c), 64'd3);

        do_req(0, 0, 2'd2, 32'h100, 32'h0, 5, rd, e, c, ed);
        check("held_lw_rdata", 64'(rd), 64'hDEAD55EF);

        // Reset while the load response has just become valid.
        @(negedge clk);
        req_we = 0; req_size = 2'd2; req_addr = 32'h100; req_signed = 0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_reset_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #2;
            check("post_reset_no_stale", 64'(resp_valid), 64'd0);
            check("post_reset_req_ready", 64'(req_ready), 64'd1);
        end
        do_req(0, 0, 2'd2, 32'h100, 32'h0, 0, rd, e, c, ed);
        check("lw_after_reset", 64'(rd), 64'hDEAD55EF);

        for (int k = 0; k < 16; k++)
            do_req(1, 0, 2'd2, 32'h200 + 32'(4*k), $urandom, 0, rd, e, c, ed);

        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            req_valid  = ($urandom_range(0, 2) != 0);
            req_we     = 1'($urandom_range(0, 1));
            req_signed = 1'($urandom_range(0, 1));
            req_size   = 2'($urandom_range(0, 3));
            req_addr   = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 255))
                                                     : 32'h200 + 32'($urandom_range(0, 63));
            req_wdata  = $urandom;
            resp_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (10) @(negedge clk);
        resp_ready = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
